// File: rtl/ffdiv_issuer.sv
// Job issuer for a multi-cycle FP divider: one job in flight, responses queued in a FIFO.
// Optional busy-timeout abort enabled with `define FFDIV_ISSUER_TIMEOUT_EN.
module ffdiv_issuer #(
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_en,
    output logic [31:0]      div_operand1,
    output logic [31:0]      div_operand2,
    input  logic             div_ready,
    input  logic [31:0]      div_result,
    input  logic [4:0]       div_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flag,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef FFDIV_ISSUER_TIMEOUT_EN
    localparam int unsigned ENT_W = 38 + TAG_W;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
`else
    localparam int unsigned ENT_W = 37 + TAG_W;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StCapt} state_e;

    state_e             state_q, state_d;
    logic [31:0]        op1_q, op2_q, res_q;
    logic [4:0]         flag_q;
    logic [TAG_W-1:0]   tag_q;
    logic [ENT_W-1:0]   mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               accept, push, pop;
    logic [ENT_W-1:0]   push_data, head;
`ifdef FFDIV_ISSUER_TIMEOUT_EN
    logic [TMR_W-1:0]   timer_q;
    logic               push_timeout;
`endif

    assign accept = req_valid && req_ready;
    assign pop    = rsp_valid && rsp_ready;
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
`ifdef FFDIV_ISSUER_TIMEOUT_EN
        push_timeout = 1'b0;
`endif
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: begin
                if (div_ready) begin
                    state_d = StCapt;
`ifdef FFDIV_ISSUER_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // Abort: queue a NaN response flagged as timed out.
                    push         = 1'b1;
                    push_timeout = 1'b1;
                    state_d      = StIdle;
`endif
                end
            end
            StCapt: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef FFDIV_ISSUER_TIMEOUT_EN
    assign push_data = push_timeout ? {32'h7FC00000, 5'b10000, tag_q, 1'b1}
                                    : {res_q, flag_q, tag_q, 1'b0};
`else
    assign push_data = {res_q, flag_q, tag_q};
`endif

    // All outputs are forced to zero while reset is asserted.
    always_comb begin
        req_ready    = 1'b0;
        div_en       = 1'b0;
        div_operand1 = '0;
        div_operand2 = '0;
        rsp_valid    = 1'b0;
        rsp_result   = '0;
        rsp_flag     = '0;
        rsp_tag      = '0;
        rsp_timeout  = 1'b0;
        if (!rst) begin
            req_ready    = (state_q == StIdle) && (count_q < CNT_W'(RSP_DEPTH));
            div_en       = (state_q == StBusy);
            div_operand1 = op1_q;
            div_operand2 = op2_q;
            rsp_valid    = (count_q != '0);
            rsp_result   = head[ENT_W-1 -: 32];
            rsp_flag     = head[ENT_W-33 -: 5];
            rsp_tag      = head[ENT_W-38 -: TAG_W];
`ifdef FFDIV_ISSUER_TIMEOUT_EN
            rsp_timeout  = head[0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op1_q    <= '0;
            op2_q    <= '0;
            tag_q    <= '0;
            res_q    <= '0;
            flag_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef FFDIV_ISSUER_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q <= req_op1;
                op2_q <= req_op2;
                tag_q <= req_tag;
            end
            if (state_q == StBusy && div_ready) begin
                res_q  <= div_result;
                flag_q <= div_flag;
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
`ifdef FFDIV_ISSUER_TIMEOUT_EN
            if (accept)                 timer_q <= '0;
            else if (state_q == StBusy) timer_q <= timer_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: doc/ffdiv_issuer.md
FFDIV_ISSUER -- requirements
Module: ffdiv_issuer

Interface
REQ-001 SHALL have parameter TAG_W, default 4: request/response tag width.
REQ-002 SHALL have parameter RSP_DEPTH, default 4: response FIFO entries, power of two.
REQ-003 SHALL have parameter TIMEOUT, default 64: max cycles in BUSY before abort.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1: upstream job handshake.
REQ-007 SHALL have ports req_op1 in 32, req_op2 in 32, req_tag in TAG_W: dividend, divisor, job tag.
REQ-008 SHALL have ports div_en out 1, div_operand1 out 32, div_operand2 out 32: drive to divider.
REQ-009 SHALL have ports div_ready in 1, div_result in 32, div_flag in 5 {nanf,ovf,inf,uf,zf}: from divider.
REQ-010 SHALL have ports rsp_valid out 1 / rsp_ready in 1: downstream response handshake.
REQ-011 SHALL have ports rsp_result out 32, rsp_flag out 5, rsp_tag out TAG_W, rsp_timeout out 1: response payload.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, CAPT.
REQ-013 SHALL assert req_ready only in IDLE with response FIFO count < RSP_DEPTH.
REQ-014 SHALL, on req_valid && req_ready, register op1/op2/tag and enter BUSY next cycle.
REQ-015 SHALL hold div_en=1 and div_operand1/2 stable for every BUSY cycle; div_en=0 in IDLE and CAPT.
REQ-016 SHALL, in BUSY with div_ready=1, go to CAPT next cycle; divider result registers update on that edge.
REQ-017 SHALL, in CAPT, push {div_result, div_flag, tag, timeout=0} into the response FIFO, then return to IDLE.
REQ-018 SHALL give 1 cycle from IDLE accept to div_en high, and 1 cycle from CAPT to rsp_valid high if the FIFO was empty.
REQ-019 SHALL present the FIFO head on rsp_* with rsp_valid=(count!=0); pop on rsp_valid && rsp_ready.
REQ-020 SHALL support push and pop in the same cycle with count unchanged and data order preserved.
REQ-021 SHALL wrap FIFO read/write pointers modulo RSP_DEPTH.
REQ-022 SHALL ignore div_ready outside BUSY.
REQ-023 SHALL never push into a full FIFO; admission control (REQ-013) guarantees one free slot per accepted job.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set state=IDLE, FIFO count/pointers=0, timeout counter=0.
REQ-025 SHALL drive, during reset, div_en=0, div_operand1/2=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flag=0, rsp_tag=0, rsp_timeout=0.
REQ-026 SHALL abort an in-flight job on reset mid-operation, dropping its response and all FIFO contents.

Configuration
REQ-027 SHALL, with FFDIV_ISSUER_TIMEOUT_EN defined, count BUSY cycles from 0; at count TIMEOUT-1 without div_ready, drop div_en, push {32'h7FC00000, 5'b10000, tag, timeout=1}, return to IDLE.
REQ-028 SHALL give div_ready priority over timeout when both occur in the same cycle (normal CAPT path).
REQ-029 SHALL, without FFDIV_ISSUER_TIMEOUT_EN, omit the counter, wait in BUSY indefinitely, and tie rsp_timeout=0.

Verification
REQ-030 SHALL cover: op1=32'h40C00000, op2=32'h40000000, tag=3, model ready after 10 cycles -> rsp_result=32'h40400000, rsp_flag=0, rsp_tag=3, rsp_timeout=0.
REQ-031 SHALL cover: 5 back-to-back jobs with rsp_ready=0 -> exactly 4 accepted, req_ready=0 after the 4th CAPT; then rsp_ready=1 -> tags drained in order 0..3, 5th job accepted.
REQ-032 SHALL cover: op2=0, model returns 32'h7F800000, flag 5'b00100 -> rsp_flag=5'b00100, rsp_result=32'h7F800000.
REQ-033 SHALL cover, with the macro: model never asserts div_ready -> div_en drops after 64 BUSY cycles; response 32'h7FC00000, flag 5'b10000, rsp_timeout=1.
REQ-034 SHALL cover: rst=1 for one cycle mid-BUSY with 2 FIFO entries -> next cycle div_en=0, rsp_valid=0, req_ready=1.
REQ-035 SHALL cover: CAPT push coincident with rsp pop at count=2 -> count stays 2, order preserved.
